// File: rtl/hdmi_video_pkg.sv
// Shared constants for the HDMI video source: default 640x480@60 timing,
// colour-bar palette and test-pattern encodings.
package hdmi_video_pkg;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_BLACK    = 2'd3
    } pattern_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Bar palette, index 0 is the leftmost bar
    localparam logic [7:0][23:0] BAR_COLORS = {
        COL_BLACK, COL_BLUE, COL_RED, COL_MAGENTA,
        COL_GREEN, COL_CYAN, COL_YELLOW, COL_WHITE
    };

endpackage

// File: rtl/video_timing_gen_pattern_gen.sv
// Combinational test-pattern generator: pixel position + pattern -> RGB.
// The caller registers the result and applies blanking.
module pattern_gen
    import hdmi_video_pkg::*;
#(
    parameter int CW       = 12,
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [CW-1:0] x,
    input  logic [7:0]    y,
    input  pattern_e      pattern,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [23:0] rgb;

    // Bar index from a ladder of constant compares; smallest matching bound wins
    always_comb begin
        bar = 3'd7;
        for (int k = 7; k >= 1; k--) begin
            if (32'(x) < k * BAR_W) bar = 3'(k - 1);
        end
    end

    // Pattern select
    always_comb begin
        rgb = COL_BLACK;
        case (pattern)
            PAT_BARS:     rgb = BAR_COLORS[bar];
            PAT_GRADIENT: rgb = {x[7:0], y, x[7:0] ^ y};
            PAT_CHECKER:  rgb = (x[5] ^ y[5]) ? COL_WHITE : COL_BLACK;
            default:      rgb = COL_BLACK;
        endcase
    end

    assign {red, green, blue} = rgb;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI path: h/v counters, syncs, data
// enable, pixel coordinates and a frame-locked test pattern. Every output is
// registered once, so all outputs describe the same counter position.
module video_timing_gen
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk_low,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap;
    logic          active, hs_on, vs_on, frame_top, visible;
    pattern_e      pat_q, pat_eff;
    logic [7:0]    pg_red, pg_green, pg_blue;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign frame_top = (h_cnt == '0) && (v_cnt == '0);
    assign visible   = enable && active;

    // The first pixel of a frame already uses the freshly sampled selection;
    // everywhere else the frame-locked copy is used, so a change never tears.
    assign pat_eff = frame_top ? pattern_e'(pattern_sel) : pat_q;

    // Raster counters; frozen while disabled so the raster resumes in place
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
        end
    end

    // Latch the pattern selection once per frame at the top-left pixel
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n)                pat_q <= PAT_BARS;
        else if (enable && frame_top) pat_q <= pattern_e'(pattern_sel);
    end

    pattern_gen #(
        .CW       (CW),
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .x       (h_cnt),
        .y       (v_cnt[7:0]),
        .pattern (pat_eff),
        .red     (pg_red),
        .green   (pg_green),
        .blue    (pg_blue)
    );

    // Output register stage: one cycle behind the counters, blanked when disabled
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (enable && hs_on) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (enable && vs_on) ? SYNC_POL : ~SYNC_POL;
            de          <= visible;
            x           <= visible ? h_cnt : '0;
            y           <= visible ? v_cnt : '0;
            red         <= visible ? pg_red   : '0;
            green       <= visible ? pg_green : '0;
            blue        <= visible ? pg_blue  : '0;
            frame_start <= enable && frame_top;
        end
    end

    // Completed-frame counter, bumped as the raster leaves the last position
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n)                         frame_count <= '0;
        else if (enable && h_wrap && v_wrap) frame_count <= frame_count + 16'd1;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default 640x480 instance (a) for reset, line timing, bars
// and enable gating, and a small-raster instance (b, 160x50 total) for frame
// timing and pattern switching so whole frames stay short.
module tb_video_timing_gen;

    logic        clk_low = 1'b0;
    logic        reset_n;
    logic        en_a, en_b;
    logic [1:0]  sel_a, sel_b;

    logic        hs_a, vs_a, de_a, fs_a;
    logic [11:0] x_a, y_a;
    logic [7:0]  r_a, g_a, b_a;
    logic [15:0] fc_a;

    logic        hs_b, vs_b, de_b, fs_b;
    logic [11:0] x_b, y_b;
    logic [7:0]  r_b, g_b, b_b;
    logic [15:0] fc_b;

    int checks = 0;
    int errors = 0;
    int pb;

    always #5 clk_low = ~clk_low;

    video_timing_gen dut_a (
        .clk_low(clk_low), .reset_n(reset_n), .enable(en_a), .pattern_sel(sel_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .red(r_a), .green(g_a), .blue(b_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(128), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(40),  .V_FP(3), .V_SYNC(2),  .V_BP(5)
    ) dut_b (
        .clk_low(clk_low), .reset_n(reset_n), .enable(en_b), .pattern_sel(sel_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .red(r_b), .green(g_b), .blue(b_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    task automatic tick();
        @(posedge clk_low);
        #1;
    endtask

    // advance instance b to sample position t counted from its frame start
    task automatic goto_b(input int t);
        while (pb < t) begin
            tick();
            pb++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en_a = 1'b1; en_b = 1'b1; sel_a = 2'd0; sel_b = 2'd0;
        repeat (3) tick();
        checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL rst_sync got %b exp 11", {hs_a, vs_a}); end
        checks++; if ({r_a, g_a, b_a} !== 24'h0) begin errors++; $display("FAIL rst_rgb got %h exp 000000", {r_a, g_a, b_a}); end
        checks++; if ({de_a, fs_a, x_a, y_a, fc_a} !== '0) begin errors++; $display("FAIL rst_misc de=%b fs=%b x=%0d y=%0d fc=%0d exp all 0", de_a, fs_a, x_a, y_a, fc_a); end
        checks++; if ({hs_b, vs_b, de_b} !== 3'b110) begin errors++; $display("FAIL rst_b got %b exp 110", {hs_b, vs_b, de_b}); end
        reset_n = 1'b1;
        tick();
        checks++; if ({de_a, fs_a} !== 2'b11) begin errors++; $display("FAIL first_pix de=%b fs=%b exp 1 1", de_a, fs_a); end
        checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin errors++; $display("FAIL first_xy got %0d,%0d exp 0,0", x_a, y_a); end
        checks++; if (fs_b !== 1'b1) begin errors++; $display("FAIL first_fs_b got %b exp 1", fs_b); end
    endtask

    // one full line of instance a starting at the current (first) sample
    task automatic test_line();
        int          bx[5] = '{0, 79, 80, 400, 639};
        logic [23:0] bc[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000};
        for (int i = 0; i <= 800; i++) begin
            int   ii;
            logic e_de, e_hs;
            ii   = i % 800;
            e_de = (ii < 640);
            e_hs = !(ii >= 656 && ii < 752);
            checks++; if (de_a !== e_de) begin errors++; $display("FAIL line_de i=%0d got %b exp %b", i, de_a, e_de); end
            checks++; if (hs_a !== e_hs) begin errors++; $display("FAIL line_hs i=%0d got %b exp %b", i, hs_a, e_hs); end
            checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL line_vs i=%0d got %b exp 1", i, vs_a); end
            checks++; if (x_a !== (e_de ? 12'(ii) : 12'd0) || y_a !== (e_de ? 12'(i / 800) : 12'd0)) begin
                errors++; $display("FAIL line_xy i=%0d got %0d,%0d", i, x_a, y_a);
            end
            if (i < 800) begin
                for (int k = 0; k < 5; k++) begin
                    if (i == bx[k]) begin
                        checks++; if ({r_a, g_a, b_a} !== bc[k]) begin errors++; $display("FAIL bars x=%0d got %h exp %h", i, {r_a, g_a, b_a}, bc[k]); end
                    end
                end
            end
            if (i < 800) tick();
        end
    endtask

    // one full frame of instance b: vsync window, frame_start period, counter
    task automatic test_frame();
        int n = 0;
        logic [15:0] fc0;
        while (fs_b !== 1'b1 && n < 9000) begin tick(); n++; end
        checks++; if (n >= 9000) begin errors++; $display("FAIL frame_wait got timeout exp frame_start"); end
        fc0 = fc_b;
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL frame_cnt0 got %0d exp 1", fc0); end
        for (int i = 0; i <= 8000; i++) begin
            logic e_vs, e_fs;
            e_vs = !(i >= 6880 && i < 7200);
            e_fs = (i == 0 || i == 8000);
            checks++; if (vs_b !== e_vs) begin errors++; $display("FAIL frame_vs i=%0d got %b exp %b", i, vs_b, e_vs); end
            checks++; if (fs_b !== e_fs) begin errors++; $display("FAIL frame_fs i=%0d got %b exp %b", i, fs_b, e_fs); end
            if (i == 7998) begin
                checks++; if (fc_b !== fc0) begin errors++; $display("FAIL frame_cnt_hold got %0d exp %0d", fc_b, fc0); end
            end
            if (i == 8000) begin
                checks++; if (fc_b !== fc0 + 16'd1) begin errors++; $display("FAIL frame_cnt_inc got %0d exp %0d", fc_b, fc0 + 16'd1); end
            end
            if (i < 8000) tick();
        end
    endtask

    // pattern changes mid-frame only take effect at the next frame top
    task automatic test_pattern_switch();
        int n = 0;
        while (fs_b !== 1'b1 && n < 9000) begin tick(); n++; end
        checks++; if (n >= 9000) begin errors++; $display("FAIL pat_wait got timeout exp frame_start"); end
        pb = 0;
        checks++; if ({r_b, g_b, b_b} !== 24'hFFFFFF) begin errors++; $display("FAIL pat_bars00 got %h exp FFFFFF", {r_b, g_b, b_b}); end
        goto_b(20 * 160);
        sel_b = 2'd2;
        goto_b(21 * 160 + 32);
        checks++; if ({x_b, y_b} !== {12'd32, 12'd21} || {r_b, g_b, b_b} !== 24'h00FFFF) begin
            errors++; $display("FAIL pat_no_tear x=%0d y=%0d got %h exp 00FFFF", x_b, y_b, {r_b, g_b, b_b});
        end
        goto_b(8000);
        checks++; if (fs_b !== 1'b1 || {r_b, g_b, b_b} !== 24'h000000) begin errors++; $display("FAIL pat_chk00 fs=%b got %h exp 000000", fs_b, {r_b, g_b, b_b}); end
        goto_b(8000 + 32);
        checks++; if ({r_b, g_b, b_b} !== 24'hFFFFFF) begin errors++; $display("FAIL pat_chk32_0 got %h exp FFFFFF", {r_b, g_b, b_b}); end
        goto_b(8000 + 32 * 160);
        checks++; if ({r_b, g_b, b_b} !== 24'hFFFFFF) begin errors++; $display("FAIL pat_chk0_32 got %h exp FFFFFF", {r_b, g_b, b_b}); end
        goto_b(8000 + 32 * 160 + 32);
        checks++; if ({x_b, y_b} !== {12'd32, 12'd32} || {r_b, g_b, b_b} !== 24'h000000) begin
            errors++; $display("FAIL pat_chk32_32 x=%0d y=%0d got %h exp 000000", x_b, y_b, {r_b, g_b, b_b});
        end
        sel_b = 2'd1;
        goto_b(16000 + 3 * 160 + 5);
        checks++; if ({r_b, g_b, b_b} !== 24'h050306) begin errors++; $display("FAIL pat_grad got %h exp 050306", {r_b, g_b, b_b}); end
    endtask

    // drop enable for 50 cycles mid-line; raster must resume in place
    task automatic test_enable();
        int n = 0;
        logic [11:0] y0;
        while (!(de_a === 1'b1 && x_a == 12'd299 && y_a < 12'd400) && n < 2000) begin tick(); n++; end
        checks++; if (n >= 2000) begin errors++; $display("FAIL en_wait got timeout exp x=299"); end
        y0 = y_a;
        en_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            checks++; if ({de_a, fs_a, hs_a} !== 3'b001 || {r_a, g_a, b_a} !== 24'h0) begin
                errors++; $display("FAIL en_blank k=%0d de=%b fs=%b hs=%b rgb=%h exp 0 0 1 000000", k, de_a, fs_a, hs_a, {r_a, g_a, b_a});
            end
        end
        en_a = 1'b1;
        tick();
        checks++; if (de_a !== 1'b1 || x_a !== 12'd300 || y_a !== y0) begin
            errors++; $display("FAIL en_resume de=%b x=%0d y=%0d exp 1 300 %0d", de_a, x_a, y_a, y0);
        end
        n = 0;
        do begin tick(); n++; end while (!(de_a === 1'b1 && x_a == 12'd0) && n < 1000);
        checks++; if (n !== 500 || y_a !== y0 + 12'd1) begin
            errors++; $display("FAIL en_line_len got %0d cycles y=%0d exp 500 y=%0d", n, y_a, y0 + 12'd1);
        end
    endtask

    // reset asserted between edges clears outputs immediately, raster restarts
    task automatic test_async_reset();
        @(posedge clk_low);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({de_a, hs_a, vs_a, fs_a} !== 4'b0110 || {r_a, g_a, b_a} !== 24'h0 || x_a !== 12'd0) begin
            errors++; $display("FAIL arst_a de=%b hs=%b vs=%b fs=%b rgb=%h x=%0d", de_a, hs_a, vs_a, fs_a, {r_a, g_a, b_a}, x_a);
        end
        checks++; if (fc_b !== 16'd0) begin errors++; $display("FAIL arst_fc got %0d exp 0", fc_b); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if ({de_a, fs_a} !== 2'b11 || x_a !== 12'd0 || y_a !== 12'd0) begin
            errors++; $display("FAIL arst_restart de=%b fs=%b x=%0d y=%0d exp 1 1 0 0", de_a, fs_a, x_a, y_a);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_pattern_switch();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
